// File: rtl/pfd_tdc_5bit_pkg.sv
// Shared ADPLL constants: phase-detector state encodings and the control word
// format consumed directly by dco_5bit.
package pfd_tdc_5bit_pkg;
  localparam int CTRL_W   = 5;
  localparam int CTRL_SAT = 31;
  localparam int CNT_W    = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REF_LEAD = 2'd1,
    ST_DCO_LEAD = 2'd2
  } pfd_state_e;

  function automatic logic [CTRL_W-1:0] sat_ctrl(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(CTRL_SAT)) ? CTRL_W'(CTRL_SAT) : c[CTRL_W-1:0];
  endfunction
endpackage

// File: rtl/pfd_tdc_5bit_edge_sync_det.sv
// Two-flop synchronizer plus registered rising-edge pulse; a level that is
// already high when reset releases is not reported until it falls and rises.
module edge_sync_det (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);
  logic meta_q, sync_q, prev_q;
  logic fill1_q, fill2_q, armed_q, pulse_q;

  // fill*_q mark when sync_q holds real input rather than its reset value;
  // armed_q then requires one genuine low before any edge is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      fill1_q <= 1'b0;
      fill2_q <= 1'b0;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= async_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      fill1_q <= 1'b1;
      fill2_q <= fill1_q;
      armed_q <= armed_q | (fill2_q & ~sync_q);
      pulse_q <= sync_q & ~prev_q & armed_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/pfd_tdc_5bit.sv
// Counter-based phase/frequency detector: measures the clk-cycle distance
// between ref and dco rising edges, signed by which one arrived first.
module pfd_tdc_5bit
  import pfd_tdc_5bit_pkg::*;
#(
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ref_clk,
  input  logic              dco_clk,
  output logic              ctrl_sign,
  output logic [CTRL_W-1:0] ctrl,
  output logic              ctrl_valid,
  output logic              timeout
);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic              ref_pulse, dco_pulse, lag_pulse;
  pfd_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              sign_q, valid_q, to_q;
  logic [CTRL_W-1:0] ctrl_q;

  edge_sync_det u_ref_det (.clk(clk), .reset(reset), .async_i(ref_clk), .pulse_o(ref_pulse));
  edge_sync_det u_dco_det (.clk(clk), .reset(reset), .async_i(dco_clk), .pulse_o(dco_pulse));

  // Only the trailing source can close a measurement; repeats of the leader are ignored.
  assign lag_pulse = (state_q == ST_REF_LEAD) ? dco_pulse : ref_pulse;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      to_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ref_pulse && dco_pulse) begin
            sign_q  <= 1'b0;
            ctrl_q  <= '0;
            valid_q <= 1'b1;
          end else if (ref_pulse) begin
            state_q <= ST_REF_LEAD;
            cnt_q   <= CNT_W'(1);
          end else if (dco_pulse) begin
            state_q <= ST_DCO_LEAD;
            cnt_q   <= CNT_W'(1);
          end
        end
        ST_REF_LEAD, ST_DCO_LEAD: begin
          if (lag_pulse || (cnt_q == TIMEOUT_CNT)) begin
            sign_q  <= (state_q == ST_DCO_LEAD);
            ctrl_q  <= lag_pulse ? sat_ctrl(cnt_q) : CTRL_W'(CTRL_SAT);
            valid_q <= 1'b1;
            to_q    <= ~lag_pulse;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ctrl_sign  = sign_q;
  assign ctrl       = ctrl_q;
  assign ctrl_valid = valid_q;
  assign timeout    = to_q;
endmodule

// File: tb/tb_pfd_tdc_5bit.sv
// Self-checking bench for pfd_tdc_5bit: timestamp-based measurement model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pfd_tdc_5bit;
  localparam int TIMEOUT = 63;
  localparam int LAT     = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ref_clk = 1'b0;
  logic       dco_clk = 1'b0;
  logic       ctrl_sign, ctrl_valid, timeout;
  logic [4:0] ctrl;

  pfd_tdc_5bit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ref_clk(ref_clk), .dco_clk(dco_clk),
    .ctrl_sign(ctrl_sign), .ctrl(ctrl), .ctrl_valid(ctrl_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a measurement is a pair of sampled rising edges; the result is the
  // sample-index difference, surfacing a fixed LAT cycles after the closing edge.
  typedef struct packed {
    logic       v;
    logic       s;
    logic [4:0] m;
    logic       t;
  } ev_t;

  ev_t pipe [LAT];
  ev_t exp_now;
  int  cyc = 0, start = 0;
  bit  open = 0, lead_dco = 0, prev_r = 1, prev_d = 1;
  int  held_s = 0, held_m = 0;

  always @(posedge clk) begin
    ev_t ev;
    bit rr, dr, lag;
    ev = '0;
    cyc++;
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
      exp_now = '0;
      held_s = 0; held_m = 0;
      open = 0; prev_r = 1; prev_d = 1;
    end else begin
      rr = ref_clk & ~prev_r;
      dr = dco_clk & ~prev_d;
      prev_r = ref_clk;
      prev_d = dco_clk;
      if (!open) begin
        if (rr && dr) begin
          ev.v = 1'b1;
        end else if (rr || dr) begin
          open = 1; lead_dco = dr; start = cyc;
        end
      end else begin
        lag = lead_dco ? rr : dr;
        if (lag || (cyc - start == TIMEOUT)) begin
          ev.v = 1'b1;
          ev.s = lead_dco;
          ev.m = 5'((cyc - start > 31) ? 31 : cyc - start);
          ev.t = !lag;
          open = 0;
        end
      end
      exp_now = pipe[LAT-1];
      for (int i = LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = ev;
      if (exp_now.v) begin
        held_s = int'(exp_now.s);
        held_m = int'(exp_now.m);
      end
    end
  end

  int n_strobe = 0;
  int last_ctrl = 0, last_sign = 0, last_to = 0;

  always @(posedge clk) begin
    #1;
    check("ctrl_valid", int'(ctrl_valid), int'(exp_now.v));
    check("timeout", int'(timeout), int'(exp_now.t));
    check("ctrl_sign", int'(ctrl_sign), held_s);
    check("ctrl", int'(ctrl), held_m);
    if (ctrl_valid) begin
      n_strobe++;
      last_ctrl = int'(ctrl);
      last_sign = int'(ctrl_sign);
      last_to   = int'(timeout);
    end
  end

  function automatic bit hi(input int c, input int r);
    return (r >= 0) && (c >= r) && (c < r + 2);
  endfunction

  task automatic run(input int r0, input int r1, input int d0, input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      ref_clk = hi(c, r0) | hi(c, r1);
      dco_clk = hi(c, d0);
    end
    @(negedge clk);
    ref_clk = 1'b0;
    dco_clk = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic scen(input string name, input int r0, input int r1, input int d0,
                      input int len, input int e_sign, input int e_ctrl, input int e_to);
    int n0;
    n0 = n_strobe;
    run(r0, r1, d0, len);
    check({name, "_strobes"}, n_strobe - n0, 1);
    check({name, "_sign"}, last_sign, e_sign);
    check({name, "_ctrl"}, last_ctrl, e_ctrl);
    check({name, "_to"}, last_to, e_to);
    check({name, "_model_ctrl"}, held_m, e_ctrl);
    check({name, "_model_sign"}, held_s, e_sign);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", int'(ctrl), 0);
    check("reset_valid", int'(ctrl_valid), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    scen("ref_lead7",   0, -1,  7, 20, 0,  7, 0);
    n0 = n_strobe;
    scen("dco_lead12", 12, -1,  0, 25, 1, 12, 0);
    repeat (20) @(negedge clk);
    check("hold_ctrl", int'(ctrl), 12);
    check("hold_sign", int'(ctrl_sign), 1);
    check("hold_strobes", n_strobe - n0, 1);
    scen("aligned",     0, -1,  0, 10, 0,  0, 0);
    scen("dco_lead1",   1, -1,  0, 10, 1,  1, 0);
    scen("ref_lead40",  0, -1, 40, 50, 0, 31, 0);
    scen("lag_at_to",   0, -1, 63, 72, 0, 31, 0);
    scen("ref_timeout", 0, -1, -1, 75, 0, 31, 1);
    scen("dco_timeout", -1, -1, 0, 75, 1, 31, 1);
    scen("second_ref",  0,  3,  9, 20, 0,  9, 0);

    n0 = n_strobe;
    @(negedge clk); ref_clk = 1'b1;
    repeat (2) @(negedge clk); ref_clk = 1'b0;
    repeat (6) @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    repeat (12) @(negedge clk);
    check("midreset_strobes", n_strobe - n0, 0);
    check("midreset_ctrl", int'(ctrl), 0);
    check("midreset_sign", int'(ctrl_sign), 0);
    scen("after_reset", 0, -1, 4, 15, 0, 4, 0);

    n0 = n_strobe;
    @(negedge clk); ref_clk = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    repeat (80) @(negedge clk);
    check("high_at_release_strobes", n_strobe - n0, 0);
    ref_clk = 1'b0;
    repeat (3) @(negedge clk);
    scen("after_high", 0, -1, 5, 15, 0, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
